// File: rtl/uvmt_cv32e40x_sl_pkg.sv
// Shared constants and helpers for the uvmt_cv32e40x support-logic layer.
package uvmt_cv32e40x_sl_pkg;

  localparam int unsigned OBI_TRACKER_DEPTH_DEF = 32'd2;
  localparam int unsigned OBI_TRACKER_XLEN_DEF  = 32'd1;

  // Width needed to hold an occupancy count in the range 0..depth.
  function automatic int unsigned sl_cnt_width(input int unsigned depth);
    return (depth < 32'd1) ? 32'd1 : $clog2(depth + 32'd1);
  endfunction

endpackage

// File: rtl/uvmt_cv32e40x_sl_wrap_ptr.sv
// Increment-with-wrap pointer: counts 0..MAX-1 while enabled, then returns to 0.
module uvmt_cv32e40x_sl_wrap_ptr #(
  parameter int unsigned MAX = 32'd2,
  parameter int unsigned W   = 32'd1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(MAX - 32'd1);

  // Pointer register; wraps at the last slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= {W{1'b0}};
    end else if (en) begin
      ptr <= (ptr == LAST) ? {W{1'b0}} : ptr + W'(1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/uvmt_cv32e40x_sl_obi_req_tracker.sv
// OBI request/response tracker: FIFO of per-request attributes with sticky error flags.
// Optional embedded assertions: define UVMT_CV32E40X_SL_OBI_TRACKER_ASSERT_EN.
module uvmt_cv32e40x_sl_obi_req_tracker
  import uvmt_cv32e40x_sl_pkg::*;
#(
  parameter  int unsigned XLEN  = OBI_TRACKER_XLEN_DEF,
  parameter  int unsigned DEPTH = OBI_TRACKER_DEPTH_DEF,
  localparam int unsigned CNT_W = sl_cnt_width(DEPTH),
  localparam int unsigned PTR_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             gnt_i,
  input  logic             rvalid_i,
  input  logic [XLEN-1:0]  req_attr_i,
  output logic [XLEN-1:0]  resp_attr_o,
  output logic             resp_attr_valid_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_err_o,
  output logic             underflow_err_o
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;
  logic             is_full;
  logic             rd_en;
  logic             wr_en;
  logic             overflow_err;
  logic             underflow_err;

  // A full tracker still accepts when a response frees a slot in the same cycle.
  always_comb begin
    accept  = req_i && gnt_i;
    is_full = (count == DEPTH_CNT);
    rd_en   = rvalid_i && (count != {CNT_W{1'b0}});
    wr_en   = accept && (!is_full || rd_en);
  end

  always_comb begin
    resp_attr_valid_o = rd_en;
    if (rd_en) begin
      resp_attr_o = mem[rd_ptr];
    end else begin
      resp_attr_o = {XLEN{1'b0}};
    end
  end

  assign outstanding_o   = count;
  assign empty_o         = (count == {CNT_W{1'b0}});
  assign full_o          = is_full;
  assign overflow_err_o  = overflow_err;
  assign underflow_err_o = underflow_err;

  uvmt_cv32e40x_sl_wrap_ptr #(.MAX(DEPTH), .W(PTR_W)) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en     (wr_en),
    .ptr    (wr_ptr)
  );

  uvmt_cv32e40x_sl_wrap_ptr #(.MAX(DEPTH), .W(PTR_W)) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en     (rd_en),
    .ptr    (rd_ptr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= {XLEN{1'b0}};
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= req_attr_i;
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= {CNT_W{1'b0}};
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= overflow_err  || (accept && is_full && !rvalid_i);
      underflow_err <= underflow_err || (rvalid_i && (count == {CNT_W{1'b0}}));
    end
  end

`ifdef UVMT_CV32E40X_SL_OBI_TRACKER_ASSERT_EN
  if (DEPTH < 32'd1) begin : g_depth_chk
    $error("uvmt_cv32e40x_sl_obi_req_tracker: DEPTH must be >= 1");
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(accept && is_full && !rvalid_i))
    else $error("obi_req_tracker: request granted while tracker full");

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rvalid_i && empty_o))
    else $error("obi_req_tracker: response with no outstanding request");

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_o <= DEPTH_CNT)
    else $error("obi_req_tracker: outstanding count exceeds DEPTH");

  a_empty_full_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(empty_o && full_o))
    else $error("obi_req_tracker: empty and full both asserted");
`endif

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_obi_req_tracker.sv
// Directed scoreboard bench: one DEPTH=2/XLEN=1 and one DEPTH=3/XLEN=4 tracker.
module tb_uvmt_cv32e40x_sl_obi_req_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req2 = 1'b0, gnt2 = 1'b0, rv2 = 1'b0;
  logic [0:0] attr2 = 1'b0;
  logic [0:0] ra2;
  logic       rav2, emp2, full2, ovf2, unf2;
  logic [1:0] outs2;

  logic       req3 = 1'b0, gnt3 = 1'b0, rv3 = 1'b0;
  logic [3:0] attr3 = 4'h0;
  logic [3:0] ra3;
  logic       rav3, emp3, full3, ovf3, unf3;
  logic [1:0] outs3;

  uvmt_cv32e40x_sl_obi_req_tracker #(.XLEN(1), .DEPTH(2)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .gnt_i(gnt2), .rvalid_i(rv2),
    .req_attr_i(attr2), .resp_attr_o(ra2), .resp_attr_valid_o(rav2),
    .outstanding_o(outs2), .empty_o(emp2), .full_o(full2),
    .overflow_err_o(ovf2), .underflow_err_o(unf2));

  uvmt_cv32e40x_sl_obi_req_tracker #(.XLEN(4), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .gnt_i(gnt3), .rvalid_i(rv3),
    .req_attr_i(attr3), .resp_attr_o(ra3), .resp_attr_valid_o(rav3),
    .outstanding_o(outs3), .empty_o(emp3), .full_o(full3),
    .overflow_err_o(ovf3), .underflow_err_o(unf3));

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected attributes in request order, plus expected sticky flags.
  logic [3:0] q2[$];
  logic [3:0] q3[$];
  logic m_ovf2 = 1'b0, m_unf2 = 1'b0, m_ovf3 = 1'b0, m_unf3 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string nm, input int sel, input logic rq, input logic gt,
                      input logic rv, input logic [3:0] a);
    int sz, dep;
    logic exp_valid, acc, pop;
    logic [3:0] exp_attr;
    @(negedge clk);
    if (sel == 2) begin
      req2 = rq; gnt2 = gt; rv2 = rv; attr2 = a[0:0];
      req3 = 1'b0; gnt3 = 1'b0; rv3 = 1'b0;
      sz = q2.size(); dep = 2;
    end else begin
      req3 = rq; gnt3 = gt; rv3 = rv; attr3 = a;
      req2 = 1'b0; gnt2 = 1'b0; rv2 = 1'b0;
      sz = q3.size(); dep = 3;
    end
    exp_valid = rv && (sz != 0);
    exp_attr  = 4'h0;
    if (exp_valid) exp_attr = (sel == 2) ? q2[0] : q3[0];
    #1;
    chk({nm, ".resp_valid"}, (sel == 2) ? {31'd0, rav2} : {31'd0, rav3}, {31'd0, exp_valid});
    chk({nm, ".resp_attr"}, (sel == 2) ? {31'd0, ra2} : {28'd0, ra3}, {28'd0, exp_attr});
    @(posedge clk);
    acc = rq && gt;
    pop = rv && (sz != 0);
    if (sel == 2) begin
      if (pop) void'(q2.pop_front());
      if (acc && (sz < dep || pop)) q2.push_back({3'b000, a[0]});
      if (acc && sz == dep && !rv) m_ovf2 = 1'b1;
      if (rv && sz == 0) m_unf2 = 1'b1;
    end else begin
      if (pop) void'(q3.pop_front());
      if (acc && (sz < dep || pop)) q3.push_back(a);
      if (acc && sz == dep && !rv) m_ovf3 = 1'b1;
      if (rv && sz == 0) m_unf3 = 1'b1;
    end
    #1;
    if (sel == 2) begin
      chk({nm, ".outstanding"}, {30'd0, outs2}, q2.size());
      chk({nm, ".empty"}, {31'd0, emp2}, {31'd0, q2.size() == 0});
      chk({nm, ".full"}, {31'd0, full2}, {31'd0, q2.size() == 2});
      chk({nm, ".ovf"}, {31'd0, ovf2}, {31'd0, m_ovf2});
      chk({nm, ".unf"}, {31'd0, unf2}, {31'd0, m_unf2});
    end else begin
      chk({nm, ".outstanding"}, {30'd0, outs3}, q3.size());
      chk({nm, ".empty"}, {31'd0, emp3}, {31'd0, q3.size() == 0});
      chk({nm, ".full"}, {31'd0, full3}, {31'd0, q3.size() == 3});
      chk({nm, ".ovf"}, {31'd0, ovf3}, {31'd0, m_ovf3});
      chk({nm, ".unf"}, {31'd0, unf3}, {31'd0, m_unf3});
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".d2_valid"}, {31'd0, rav2}, 32'd0);
    chk({nm, ".d2_attr"}, {31'd0, ra2}, 32'd0);
    chk({nm, ".d2_outs"}, {30'd0, outs2}, 32'd0);
    chk({nm, ".d2_empty"}, {31'd0, emp2}, 32'd1);
    chk({nm, ".d2_full"}, {31'd0, full2}, 32'd0);
    chk({nm, ".d2_errs"}, {30'd0, ovf2, unf2}, 32'd0);
    chk({nm, ".d3_valid"}, {31'd0, rav3}, 32'd0);
    chk({nm, ".d3_attr"}, {28'd0, ra3}, 32'd0);
    chk({nm, ".d3_outs"}, {30'd0, outs3}, 32'd0);
    chk({nm, ".d3_empty"}, {31'd0, emp3}, 32'd1);
    chk({nm, ".d3_full"}, {31'd0, full3}, 32'd0);
    chk({nm, ".d3_errs"}, {30'd0, ovf3, unf3}, 32'd0);
  endtask

  initial begin
    #3;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Two-deep in-order return, full after the second accept.
    step("t1a", 2, 1'b1, 1'b1, 1'b0, 4'h1);
    step("t1b", 2, 1'b1, 1'b1, 1'b0, 4'h0);
    step("t1c", 2, 1'b0, 1'b0, 1'b1, 4'h0);
    step("t1d", 2, 1'b0, 1'b0, 1'b1, 4'h0);

    // Same-cycle accept and response returns the older entry.
    step("t2a", 3, 1'b1, 1'b1, 1'b0, 4'hA);
    step("t2b", 3, 1'b1, 1'b1, 1'b1, 4'hB);
    step("t2c", 3, 1'b0, 1'b0, 1'b1, 4'h0);

    // Five pairs across pointer wrap, then fill to full and swap at full.
    for (int i = 1; i <= 5; i++) begin
      step("t3acc", 3, 1'b1, 1'b1, 1'b0, 4'(i));
      step("t3rsp", 3, 1'b0, 1'b0, 1'b1, 4'h0);
    end
    step("t3f1", 3, 1'b1, 1'b1, 1'b0, 4'h6);
    step("t3f2", 3, 1'b1, 1'b1, 1'b0, 4'h9);
    step("t3f3", 3, 1'b1, 1'b1, 1'b0, 4'hC);
    step("t3swap", 3, 1'b1, 1'b1, 1'b1, 4'hE);
    step("t3gnt0", 3, 1'b1, 1'b0, 1'b1, 4'h3);
    step("t3d1", 3, 1'b0, 1'b1, 1'b1, 4'h0);
    step("t3d2", 3, 1'b0, 1'b0, 1'b1, 4'h0);

    // Overflow: third accept dropped, earlier entries intact.
    step("t4a", 2, 1'b1, 1'b1, 1'b0, 4'h1);
    step("t4b", 2, 1'b1, 1'b1, 1'b0, 4'h0);
    step("t4drop", 2, 1'b1, 1'b1, 1'b0, 4'h0);
    step("t4r1", 2, 1'b0, 1'b0, 1'b1, 4'h0);
    step("t4r2", 2, 1'b0, 1'b0, 1'b1, 4'h0);

    // Underflow, then accept+rvalid while empty.
    step("t5unf", 2, 1'b0, 1'b0, 1'b1, 4'h0);
    step("t5both", 2, 1'b1, 1'b1, 1'b1, 4'h1);
    step("t5r", 2, 1'b0, 1'b0, 1'b1, 4'h0);

    // Asynchronous reset between edges with entries outstanding.
    step("t6a", 2, 1'b1, 1'b1, 1'b0, 4'h1);
    step("t6b", 3, 1'b1, 1'b1, 1'b0, 4'h4);
    step("t6c", 3, 1'b1, 1'b1, 1'b0, 4'h5);
    @(negedge clk);
    rv2 = 1'b1; rv3 = 1'b1; req3 = 1'b0; gnt3 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    q2.delete(); q3.delete();
    m_ovf2 = 1'b0; m_unf2 = 1'b0; m_ovf3 = 1'b0; m_unf3 = 1'b0;
    rv2 = 1'b0; rv3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("t6acc", 3, 1'b1, 1'b1, 1'b0, 4'h7);
    step("t6rsp", 3, 1'b0, 1'b0, 1'b1, 4'h0);

    @(negedge clk);
    req2 = 1'b0; gnt2 = 1'b0; rv2 = 1'b0;
    req3 = 1'b0; gnt3 = 1'b0; rv3 = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uvmt_cv32e40x_sl_obi_req_tracker.md
Name: uvmt_cv32e40x_sl_obi_req_tracker

Overview:
Support-logic block for OBI monitors: records one attribute per granted request and presents it with the matching response.
- Generalised request/response tracker: parametrised attribute width and outstanding depth.
- Also provides occupancy status and sticky protocol-error flags.
- Instantiated in the uvmt support-logic layer next to the OBI instruction/data interfaces; feeds assertions and coverage.

Parameters:
- XLEN, 1, width of the tracked request attribute.
- DEPTH, 2, maximum outstanding (granted, not yet responded) transactions; must be >= 1; non-power-of-2 allowed.
- CNT_W, $clog2(DEPTH+1), localparam; width of the occupancy count.
- PTR_W, (DEPTH>1) ? $clog2(DEPTH) : 1, localparam; width of the read/write pointers.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- req_i  input  1  OBI request.
- gnt_i  input  1  OBI grant.
- rvalid_i  input  1  OBI response valid.
- req_attr_i  input  XLEN  attribute of the current request; sampled on accept.
- resp_attr_o  output  XLEN  attribute of the request that owns the current response.
- resp_attr_valid_o  output  1  high when rvalid_i and the tracker is non-empty.
- outstanding_o  output  CNT_W  number of outstanding transactions.
- empty_o  output  1  outstanding_o == 0.
- full_o  output  1  outstanding_o == DEPTH.
- overflow_err_o  output  1  sticky; an accept was dropped because the tracker was full.
- underflow_err_o  output  1  sticky; rvalid_i arrived while the tracker was empty.

Behaviour:
Definitions:
- accept = req_i && gnt_i.
- Storage is a circular buffer mem[DEPTH] with wr_ptr, rd_ptr and count.

Reset:
- Asynchronous, active-low; applies immediately, including mid-operation.
- Clears mem, both pointers, count and both error flags.
- Outputs during reset: resp_attr_o = 0, resp_attr_valid_o = 0, outstanding_o = 0, empty_o = 1, full_o = 0 (for DEPTH >= 1), errors = 0.

Response path (combinational, zero latency):
- resp_attr_valid_o = rvalid_i && count != 0.
- resp_attr_o = resp_attr_valid_o ? mem[rd_ptr] : '0.

Sequential update (posedge clk_i):
- accept only, count < DEPTH: mem[wr_ptr] <= req_attr_i; wr_ptr advances; count + 1.
- rvalid_i only, count > 0: rd_ptr advances; count - 1.
- accept and rvalid_i together, count > 0: write and read both happen; count unchanged.
  - The response always returns the oldest entry, never the same-cycle request (an OBI response is at least one cycle after its grant).
- accept and rvalid_i together, count == DEPTH: legal, because the slot frees in the same cycle.
- accept, count == DEPTH, no rvalid_i: attribute dropped; state unchanged; overflow_err_o <= 1.
- rvalid_i, count == 0: no pointer change; underflow_err_o <= 1.
  - If accept also occurs, the write proceeds and count becomes 1.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0.
- Error flags stay set until reset.
- Outputs are defined for any input combination; X on req_i/gnt_i/rvalid_i is not specified.

Optional Feature:
Macro UVMT_CV32E40X_SL_OBI_TRACKER_ASSERT_EN.
- Defined: embedded concurrent assertions are compiled in:
  - never overflow;
  - never underflow;
  - outstanding_o <= DEPTH;
  - empty_o and full_o are never both high;
  - plus an elaboration-time check DEPTH >= 1.
  - Each failure reports via $error.
- Undefined: no assertions; functional behaviour identical.

Decomposition:
- Package uvmt_cv32e40x_sl_pkg holds:
  - helper function sl_cnt_width(depth);
  - default constants OBI_TRACKER_DEPTH_DEF = 2 and OBI_TRACKER_XLEN_DEF = 1.
- Sub-module uvmt_cv32e40x_sl_wrap_ptr (params MAX, W): increment-with-wrap pointer with enable and async reset.
  - Instantiated twice, for wr_ptr and rd_ptr.

Test Plan:
1. DEPTH=2, XLEN=1: accept attr 1, accept attr 0, rvalid, rvalid -> resp_attr_o = 1 then 0; outstanding_o goes 1, 2, 1, 0; full_o high after the 2nd accept.
2. DEPTH=3, XLEN=4: accept 0xA; then accept 0xB with rvalid in the same cycle -> resp_attr_o = 0xA; count stays 1; the next rvalid gives 0xB.
3. DEPTH=3: 5 accept/response pairs (accepts 0x1..0x5 interleaved with responses) -> responses return 0x1..0x5 in order across pointer wrap; no error flags set.
4. DEPTH=2: three accepts with no rvalid -> 3rd dropped; overflow_err_o = 1 and stays 1; the two rvalids return the 1st and 2nd attributes.
5. rvalid with the tracker empty -> resp_attr_valid_o = 0, resp_attr_o = 0, underflow_err_o = 1; with the macro defined, an assertion error is reported.
6. Two outstanding entries, then rst_ni pulled low between clock edges -> outputs clear immediately; after release, one accept 0x7 plus rvalid returns 0x7.
